univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register with four modes: hold, shift left, shift right and parallel load. It generalises the team's fixed serial-in/serial-out register to WIDTH bits, with serial ports at both ends and a full parallel view. A shift counter raises a one-cycle `word_done` pulse after every WIDTH shifts, so serial framers and deserialisers can sit directly on it.

## Interface
- `WIDTH`, default 8, register width in bits; legal range 2 to 64.
- `CW`, default `$clog2(WIDTH)`, width of the shift counter. This is a derived localparam and is not overridden.
- `clk`  in  1  Single clock; the block acts on the rising edge.
- `reset`  in  1  Asynchronous, active-high reset. It clears all state.
- `mode`  in  2  Operation select (encodings in Operation).
- `serial_in_r`  in  1  Bit shifted into the MSB on a right shift.
- `serial_in_l`  in  1  Bit shifted into the LSB on a left shift.
- `rotate`  in  1  Rotate request. It only has an effect when `UNIV_SR_ROTATE_EN` is defined.
- `parallel_in`  in  WIDTH  Load data.
- `parallel_out`  out  WIDTH  Register contents `q`.
- `serial_out_r`  out  1  `q[0]`, combinational from the register.
- `serial_out_l`  out  1  `q[WIDTH-1]`, combinational from the register.
- `shift_count`  out  CW  Number of shifts since the last load, reset or wrap.
- `word_done`  out  1  Registered one-cycle pulse after the WIDTH-th shift.

## Operation
Mode encodings:
- `MODE_HOLD` = 2'b00: `q` and `shift_count` are unchanged.
- `MODE_SHL` = 2'b01: `q <= {q[WIDTH-2:0], serial_in_l}`.
- `MODE_SHR` = 2'b10: `q <= {serial_in_r, q[WIDTH-1:1]}`.
- `MODE_LOAD` = 2'b11: `q <= parallel_in`.

Counter:
- Each shift (SHL or SHR) increments `shift_count`.
- When a shift occurs with `shift_count == WIDTH-1`, the counter wraps to 0 and `word_done` is asserted for the following cycle.
- LOAD clears `shift_count` to 0 and never asserts `word_done`.
- HOLD freezes the counter. A HOLD between shifts does not break a word.
- Mixing SHL and SHR within one word is allowed. Both directions count the same way.

Rules and boundaries:
- `word_done` is 0 in every cycle other than the single cycle after a wrapping shift.
- Back-to-back words with no gaps give a pulse every WIDTH cycles.
- If `mode` is held at LOAD, `q` follows `parallel_in` each cycle and the counter stays at 0.
- Serial inputs are ignored in HOLD and LOAD. `parallel_in` is ignored outside LOAD.

## Timing
- All state updates happen on the rising edge of `clk`.
- `parallel_out`, `serial_out_r` and `serial_out_l` reflect the new `q` in the cycle after the edge. Latency is one cycle.
- `word_done` rises in the same cycle that `shift_count` reads 0 after a wrap.
- Asserting `reset` immediately sets `q`, `shift_count` and `word_done` to 0, regardless of `clk`. This includes reset in the middle of a word: the partial word is discarded and no `word_done` is produced.
- The first edge after `reset` deasserts is a normal operating edge.

## Configuration
- `UNIV_SR_ROTATE_EN` defined:
  - SHL with `rotate` = 1 gives `q <= {q[WIDTH-2:0], q[WIDTH-1]}`.
  - SHR with `rotate` = 1 gives `q <= {q[0], q[WIDTH-1:1]}`.
  - Rotates count as shifts for the counter and for `word_done`.
- `UNIV_SR_ROTATE_EN` not defined:
  - `rotate` is ignored.
  - Shifts always take their incoming bit from `serial_in_l` or `serial_in_r`.

## Structure
- Package `univ_sr_pkg`:
  - Contains the `mode_t` 2-bit typedef and the four `MODE_*` constants.
  - Contains a `MAX_WIDTH` = 64 constant, checked by a width assertion.
- Sub-module `sr_shift_counter`:
  - Parameter `WIDTH`. Inputs: `clk`, `reset`, `shift_en`, `clear`.
  - Outputs: `count`, and `done` registered as a pulse.
  - `univ_shift_reg` drives `shift_en` for SHL/SHR and `clear` for LOAD.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** assert `reset` with `mode`=LOAD and `parallel_in`=8'hFF → `parallel_out`=0, `shift_count`=0 and `word_done`=0 while reset is high.
- **Load then right shift:** LOAD 8'hA5, then 8 SHR with `serial_in_r`=0 → `serial_out_r` sequence 1,0,1,0,0,1,0,1. `parallel_out` ends at 8'h00. `word_done`=1 for exactly one cycle after the 8th shift.
- **Left shift:** from reset, 8 SHL with `serial_in_l` = 1,1,0,1,0,0,1,0 → `parallel_out`=8'hD2 and `word_done` pulses once.
- **Hold gap and reload:** 3 SHR, 2 HOLD, then 5 SHR → `word_done` pulses after the 10th command cycle. In a separate run, LOAD after 5 shifts → `shift_count`=0 and no pulse.
- **Mid-word reset:** reset asynchronously between clock edges after 4 shifts → `shift_count` is 0 immediately. The next 8 shifts produce exactly one `word_done`.
- **Rotate (`UNIV_SR_ROTATE_EN` defined):** LOAD 8'h81, then SHL with `rotate`=1 → `parallel_out`=8'h03. After 8 rotates total, `parallel_out`=8'h81 and `word_done` has pulsed once.

Source files
------------

// File: rtl/univ_sr_pkg.sv
// -----------------------------------------------------------------------------
// univ_sr_pkg
// Shared definitions for the universal shift register slice:
//   mode_t     - 2-bit operation select (hold / shift left / shift right / load)
//   MAX_WIDTH  - largest register width the block supports
// -----------------------------------------------------------------------------
package univ_sr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam int MAX_WIDTH = 64;

endpackage : univ_sr_pkg

// File: rtl/sr_shift_counter.sv
// -----------------------------------------------------------------------------
// sr_shift_counter
// Counts shifts modulo WIDTH and emits a registered one-cycle pulse in the
// cycle after the shift that wraps the count back to zero.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset, clears count and done
//   shift_en in   a shift happens on this edge
//   clear    in   restart the word (load); suppresses any pulse
//   count    out  shifts since last clear/reset/wrap
//   done     out  one-cycle pulse after the WIDTH-th shift
// -----------------------------------------------------------------------------
module sr_shift_counter #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          shift_en,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_r;
    logic [CW-1:0] next_count_s;
    logic          done_r;
    logic          next_done_s;

    // Next count and pulse: clear wins, then wrap on the last shift of a word.
    always_comb begin
        next_count_s = count_r;
        next_done_s  = 1'b0;
        if (clear) begin
            next_count_s = {CW{1'b0}};
            next_done_s  = 1'b0;
        end else if (shift_en) begin
            if (count_r == LAST) begin
                next_count_s = {CW{1'b0}};
                next_done_s  = 1'b1;
            end else begin
                next_count_s = count_r + CW'(1);
                next_done_s  = 1'b0;
            end
        end else begin
            next_count_s = count_r;
            next_done_s  = 1'b0;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            count_r <= next_count_s;
            done_r  <= next_done_s;
        end
    end

    assign count = count_r;
    assign done  = done_r;

endmodule : sr_shift_counter

// File: rtl/univ_shift_reg_chk.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_chk
// Elaboration-time check that the shift register width lies in 2..MAX_WIDTH.
// Parameters:
//   WIDTH - register width under check
// No ports.
// -----------------------------------------------------------------------------
module univ_shift_reg_chk
    import univ_sr_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    generate
        if ((WIDTH < 2) || (WIDTH > MAX_WIDTH)) begin : g_width_bad
            $error("univ_shift_reg: WIDTH %0d outside 2..%0d", WIDTH, MAX_WIDTH);
        end
    endgenerate

endmodule : univ_shift_reg_chk

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// WIDTH-bit universal shift register: hold, shift left, shift right, parallel
// load, with serial ports at both ends and a word_done pulse every WIDTH shifts.
// Optional feature macro: UNIV_SR_ROTATE_EN - when defined, rotate=1 makes a
// shift recirculate the outgoing bit instead of taking the serial input.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   mode         in   operation select (univ_sr_pkg::mode_t encodings)
//   serial_in_r  in   bit entering the MSB on a right shift
//   serial_in_l  in   bit entering the LSB on a left shift
//   rotate       in   rotate request (only with UNIV_SR_ROTATE_EN)
//   parallel_in  in   load data
//   parallel_out out  register contents
//   serial_out_r out  q[0]
//   serial_out_l out  q[WIDTH-1]
//   shift_count  out  shifts since last load/reset/wrap
//   word_done    out  registered pulse after the WIDTH-th shift
// -----------------------------------------------------------------------------
module univ_shift_reg
    import univ_sr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    input  logic             rotate,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_r,
    output logic             serial_out_l,
    output logic [CW-1:0]    shift_count,
    output logic             word_done
);

    mode_t            mode_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_q_s;
    logic             shl_fill_s;
    logic             shr_fill_s;
    logic             shift_en_s;
    logic             clear_s;

    assign mode_s = mode_t'(mode);

    univ_shift_reg_chk #(.WIDTH(WIDTH)) u_chk ();

`ifndef UNIV_SR_ROTATE_EN
    logic unused_rotate_s;
    assign unused_rotate_s = rotate;
`endif

    // Incoming bit for each shift direction; rotation recirculates the far end.
    always_comb begin
        shl_fill_s = serial_in_l;
        shr_fill_s = serial_in_r;
`ifdef UNIV_SR_ROTATE_EN
        if (rotate) begin
            shl_fill_s = q_r[WIDTH-1];
            shr_fill_s = q_r[0];
        end else begin
            shl_fill_s = serial_in_l;
            shr_fill_s = serial_in_r;
        end
`endif
    end

    // Next register value and counter controls per mode.
    always_comb begin
        next_q_s   = q_r;
        shift_en_s = 1'b0;
        clear_s    = 1'b0;
        case (mode_s)
            MODE_HOLD: begin
                next_q_s = q_r;
            end
            MODE_SHL: begin
                next_q_s   = {q_r[WIDTH-2:0], shl_fill_s};
                shift_en_s = 1'b1;
            end
            MODE_SHR: begin
                next_q_s   = {shr_fill_s, q_r[WIDTH-1:1]};
                shift_en_s = 1'b1;
            end
            MODE_LOAD: begin
                next_q_s = parallel_in;
                clear_s  = 1'b1;
            end
            default: begin
                next_q_s = q_r;
            end
        endcase
    end

    // Data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            q_r <= next_q_s;
        end
    end

    sr_shift_counter #(.WIDTH(WIDTH)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_s),
        .clear    (clear_s),
        .count    (shift_count),
        .done     (word_done)
    );

    assign parallel_out = q_r;
    assign serial_out_r = q_r[0];
    assign serial_out_l = q_r[WIDTH-1];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Self-checking bench for univ_shift_reg (WIDTH=8). A reference model pushes
// the expected state for every driven command; a monitor pops and compares
// one cycle later. Scenario tasks add their own targeted checks.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
`ifdef UNIV_SR_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       mode;
    logic             serial_in_r;
    logic             serial_in_l;
    logic             rotate;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out_r;
    logic             serial_out_l;
    logic [2:0]       shift_count;
    logic             word_done;

    typedef struct packed {
        logic [7:0] q;
        logic [2:0] cnt;
        logic       done;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] m_q;
    int         m_cnt;
    logic       m_done;
    int         checks;
    int         errors;
    int         done_seen;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .serial_in_r  (serial_in_r),
        .serial_in_l  (serial_in_l),
        .rotate       (rotate),
        .parallel_in  (parallel_in),
        .parallel_out (parallel_out),
        .serial_out_r (serial_out_r),
        .serial_out_l (serial_out_l),
        .shift_count  (shift_count),
        .word_done    (word_done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compare DUT state just after each edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if ({parallel_out, serial_out_r, serial_out_l, shift_count, word_done} !==
                {mon_e.q, mon_e.q[0], mon_e.q[7], mon_e.cnt, mon_e.done}) begin
                errors++;
                $display("FAIL scoreboard @%0t: got q=%h sor=%b sol=%b cnt=%0d done=%b, expected q=%h sor=%b sol=%b cnt=%0d done=%b",
                         $time, parallel_out, serial_out_r, serial_out_l, shift_count, word_done,
                         mon_e.q, mon_e.q[0], mon_e.q[7], mon_e.cnt, mon_e.done);
            end
            if (word_done === 1'b1) done_seen++;
        end
    end

    // Drive one command at the falling edge and push the model's prediction.
    task automatic drive(input logic [1:0] md, input logic sil, input logic sir,
                         input logic rot, input logic [7:0] pin);
        logic shifted;
        logic fill;
        @(negedge clk);
        mode        = md;
        serial_in_l = sil;
        serial_in_r = sir;
        rotate      = rot;
        parallel_in = pin;
        shifted = (md == 2'b01) || (md == 2'b10);
        m_done  = shifted && (m_cnt == 7);
        if (md == 2'b01) begin
            fill = (ROT_EN && rot) ? m_q[7] : sil;
            m_q  = {m_q[6:0], fill};
        end else if (md == 2'b10) begin
            fill = (ROT_EN && rot) ? m_q[0] : sir;
            m_q  = {fill, m_q[7:1]};
        end else if (md == 2'b11) begin
            m_q = pin;
        end
        if (md == 2'b11) m_cnt = 0;
        else if (shifted) m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
        sb_q.push_back(exp_t'{q: m_q, cnt: 3'(m_cnt), done: m_done});
    endtask

    // One checked HOLD edge so no stale command repeats, then let it settle.
    task automatic settle();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mode  = 2'b00;
        sb_q.delete();
        m_q    = 8'h00;
        m_cnt  = 0;
        m_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (parallel_out !== 8'h00) begin
            errors++; $display("FAIL reset_q: got %h expected 00", parallel_out);
        end
        checks++;
        if (shift_count !== 3'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", shift_count);
        end
        checks++;
        if (word_done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", word_done);
        end
        do_reset();
    endtask

    task automatic test_load_shr();
        logic [7:0] data;
        do_reset();
        data = 8'hA5;
        for (int i = 0; i <= 8; i++) begin
            if (i == 0) drive(2'b11, 1'b1, 1'b0, 1'b0, data);
            else        drive(2'b10, 1'b1, 1'b0, 1'b0, 8'hFF);
            @(posedge clk);
            #2;
            if (i < 8) begin
                checks++;
                if (serial_out_r !== data[i]) begin
                    errors++; $display("FAIL shr_serial[%0d]: got %b expected %b", i, serial_out_r, data[i]);
                end
            end
            checks++;
            if (word_done !== (i == 8)) begin
                errors++; $display("FAIL shr_done[%0d]: got %b expected %b", i, word_done, (i == 8));
            end
        end
        checks++;
        if (parallel_out !== 8'h00) begin
            errors++; $display("FAIL shr_final: got %h expected 00", parallel_out);
        end
        settle();
    endtask

    task automatic test_shl();
        logic [7:0] bits;
        do_reset();
        bits = 8'b1101_0010;
        for (int i = 0; i < 8; i++) drive(2'b01, bits[7-i], 1'b1, 1'b0, 8'hFF);
        settle();
        checks++;
        if (parallel_out !== 8'hD2) begin
            errors++; $display("FAIL shl_final: got %h expected d2", parallel_out);
        end
        checks++;
        if (done_seen !== 1) begin
            errors++; $display("FAIL shl_pulses: got %0d expected 1", done_seen);
        end
    endtask

    task automatic test_hold_gap();
        logic [1:0] md;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            md = (i >= 3 && i < 5) ? 2'b00 : 2'b10;
            drive(md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
            @(posedge clk);
            #2;
            checks++;
            if (word_done !== (i == 9)) begin
                errors++; $display("FAIL hold_gap_done[%0d]: got %b expected %b", i, word_done, (i == 9));
            end
        end
        settle();
    endtask

    task automatic test_reload();
        do_reset();
        for (int i = 0; i < 5; i++) drive(2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(2'b11, 1'b1, 1'b1, 1'b0, 8'h3C);
        @(posedge clk);
        #2;
        checks++;
        if (shift_count !== 3'd0 || parallel_out !== 8'h3C) begin
            errors++; $display("FAIL reload: got cnt=%0d q=%h expected cnt=0 q=3c", shift_count, parallel_out);
        end
        settle();
        checks++;
        if (done_seen !== 0) begin
            errors++; $display("FAIL reload_pulses: got %0d expected 0", done_seen);
        end
    endtask

    task automatic test_load_hold();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
            @(posedge clk);
            #2;
            checks++;
            if (shift_count !== 3'd0 || word_done !== 1'b0) begin
                errors++; $display("FAIL load_hold[%0d]: got cnt=%0d done=%b expected 0/0", i, shift_count, word_done);
            end
        end
        settle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++) drive(2'b10, 1'b0, 1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #3;
        reset = 1'b1;
        mode  = 2'b00;
        sb_q.delete();
        m_q = 8'h00; m_cnt = 0; m_done = 1'b0;
        #1;
        checks++;
        if (shift_count !== 3'd0 || parallel_out !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got cnt=%0d q=%h expected 0/00", shift_count, parallel_out);
        end
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) drive(2'b10, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        settle();
        checks++;
        if (done_seen !== 1) begin
            errors++; $display("FAIL mid_reset_pulses: got %0d expected 1", done_seen);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(2'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom));
            @(posedge clk);
            #2;
            checks++;
            if (word_done !== ((i % 8) == 7)) begin
                errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", i, word_done, ((i % 8) == 7));
            end
        end
        settle();
        checks++;
        if (done_seen !== 2) begin
            errors++; $display("FAIL b2b_pulses: got %0d expected 2", done_seen);
        end
    endtask

`ifdef UNIV_SR_ROTATE_EN
    task automatic test_rotate();
        do_reset();
        drive(2'b11, 1'b0, 1'b0, 1'b0, 8'h81);
        drive(2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
        @(posedge clk);
        #2;
        checks++;
        if (parallel_out !== 8'h03) begin
            errors++; $display("FAIL rotate_first: got %h expected 03", parallel_out);
        end
        for (int i = 0; i < 7; i++) drive(2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
        settle();
        checks++;
        if (parallel_out !== 8'h81 || done_seen !== 1) begin
            errors++; $display("FAIL rotate_word: got q=%h pulses=%0d expected 81/1", parallel_out, done_seen);
        end
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        done_seen   = 0;
        m_q         = 8'h00;
        m_cnt       = 0;
        m_done      = 1'b0;
        reset       = 1'b1;
        mode        = 2'b11;
        parallel_in = 8'hFF;
        serial_in_l = 1'b1;
        serial_in_r = 1'b1;
        rotate      = 1'b0;
        test_reset();
        test_load_shr();
        test_shl();
        test_hold_gap();
        test_reload();
        test_load_hold();
        test_mid_reset();
        test_back_to_back();
`ifdef UNIV_SR_ROTATE_EN
        test_rotate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_univ_shift_reg
